// File: rtl/link_tx_arbiter.sv
// link_tx_arbiter: round-robin scheduler for the 16-bit external sample link.
// Four 14-bit requesters share the link. Each owner may send up to BURST words
// before the link is re-arbitrated. A sync word is inserted every SYNC_PERIOD
// cycles, and an idle word is sent on any cycle that carries no requester word.
// Link word format: {chan[1:0], data[13:0]}.
module link_tx_arbiter #(
    parameter int unsigned BURST       = 8,
    parameter int unsigned SYNC_PERIOD = 256,
    parameter logic [15:0] SYNC_WORD   = 16'hFFFF,
    parameter logic [15:0] IDLE_WORD   = 16'h0000
) (
    input  logic        clk_ext,
    input  logic        rst,
    input  logic [3:0]  ch_en,
    input  logic [3:0]  req_valid,
    input  logic [55:0] req_data,
    output logic [3:0]  req_ready,
    output logic [15:0] link_data,
    output logic        link_valid,
    output logic        link_sync,
    output logic [1:0]  owner
);

    localparam int unsigned DATA_W     = 14;
    localparam logic [7:0]  BURST_LAST = 8'(BURST - 1);
    localparam logic [15:0] SYNC_LAST  = 16'(SYNC_PERIOD - 1);

    typedef enum logic [0:0] {ARB, XFER} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          owner_nxt;
    logic [7:0]          burst_cnt;
    logic [7:0]          burst_cnt_nxt;
    logic [15:0]         sync_cnt;
    logic                sync_due;
    logic                accept;
    logic [2:0]          pick;
    logic [DATA_W-1:0]   own_data;

    // Round-robin search: first candidate starting at last+1, wrapping 3->0.
    // The previous owner itself is considered last. Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (cand[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign sync_due = (SYNC_PERIOD != 0) && (sync_cnt == SYNC_LAST);
    assign own_data = req_data[owner*DATA_W +: DATA_W];

    // Next-state, grant and handshake logic; ready is held low while rst is
    // asserted so a requester never sees a handshake whose word gets dropped.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        req_ready     = 4'b0000;
        accept        = 1'b0;
        pick          = rr_pick(ch_en & req_valid, owner);
        case (state)
            ARB: begin
                if (pick[2]) begin
                    owner_nxt     = pick[1:0];
                    burst_cnt_nxt = 8'd0;
                    state_nxt     = XFER;
                end
            end
            XFER: begin
                req_ready[owner] = ch_en[owner] & ~sync_due & ~rst;
                accept           = req_valid[owner] & req_ready[owner];
                if (accept) burst_cnt_nxt = burst_cnt + 8'd1;
                // A sync slot neither accepts nor ends the burst on its own.
                if ((accept && (burst_cnt == BURST_LAST)) || !req_valid[owner] || !ch_en[owner])
                    state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    // Control registers: FSM state, owner, burst and sync counters.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            state     <= ARB;
            owner     <= 2'd3;
            burst_cnt <= 8'd0;
            sync_cnt  <= 16'd0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
            if (sync_due)
                sync_cnt <= 16'd0;
            else
                sync_cnt <= sync_cnt + 16'd1;
        end
    end

    // Registered link word: sync slot wins over an accepted word, else idle.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            link_data  <= IDLE_WORD;
            link_valid <= 1'b0;
            link_sync  <= 1'b0;
        end else if (sync_due) begin
            link_data  <= SYNC_WORD;
            link_valid <= 1'b0;
            link_sync  <= 1'b1;
        end else if (accept) begin
            link_data  <= {owner, own_data};
            link_valid <= 1'b1;
            link_sync  <= 1'b0;
        end else begin
            link_data  <= IDLE_WORD;
            link_valid <= 1'b0;
            link_sync  <= 1'b0;
        end
    end

endmodule
